// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_pkg                                                                  |
// | Shared CPU types: loader state encoding and datapath widths.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int PC_STEP = 2;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LEN_HI  = 4'd1,
      LEN_LO  = 4'd2,
      DATA_HI = 4'd3,
      DATA_LO = 4'd4,
      WRITE   = 4'd5,
      CSUM    = 4'd6,
      DONE    = 4'd7,
      ERROR   = 4'd8
   } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_prog_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_prog_loader_if                                                      |
// | Host byte stream plus instruction-memory write port of the loader.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface imem_prog_loader_if #(
   parameter int ADDR_W = 16
) ();
   import cpu_pkg::*;

   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic               imem_we;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_wdata;

   // master = loader, slave = host link and instruction memory
   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/byte_pair_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_pair_assembler                                                      |
// | High-byte capture register; XOR accumulator with IMEM_LOADER_CHECKSUM_EN.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module byte_pair_assembler (
   input  logic       clk,
   input  logic       rst,
`ifdef IMEM_LOADER_CHECKSUM_EN
   input  logic       clear,
   input  logic       accept,
   output logic [7:0] csum,
`endif
   input  logic       capture_hi,
   input  logic [7:0] data,
   output logic [7:0] hi_byte
);

   logic [7:0] r_hi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= 8'h00;
      end else if (capture_hi) begin
         r_hi <= data;
      end
   end

   assign hi_byte = r_hi;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_xor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xor <= 8'h00;
      end else if (clear) begin
         r_xor <= 8'h00;
      end else if (accept) begin
         r_xor <= r_xor ^ data;
      end
   end

   assign csum = r_xor;
`endif

endmodule
`default_nettype wire

// File: rtl/imem_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_prog_loader                                                         |
// | Boot loader: length-prefixed byte stream -> 16-bit imem writes, then     |
// | releases cpu_run. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module imem_prog_loader
   import cpu_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                MAX_WORDS = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   imem_prog_loader_if.master bus,
   output logic               cpu_run,
   output logic               busy,
   output logic               error,
   output logic [15:0]        words_loaded
);

   localparam logic [15:0]       c_max_words = 16'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] c_pc_step   = ADDR_W'(PC_STEP);

   loader_state_t      r_state;
   logic               r_rx_ready;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W-1:0]  r_next_addr;
   logic [INSTR_W-1:0] r_wdata;
   logic               r_cpu_run;
   logic               r_busy;
   logic               r_error;
   logic [15:0]        r_words;
   logic [15:0]        r_len;

   logic               w_accept;
   logic               w_restart;
   logic               w_capture_hi;
   logic [7:0]         w_hi_byte;
   logic [15:0]        w_pair;
   logic [15:0]        w_words_inc;

   assign w_accept     = bus.rx_valid & r_rx_ready;
   assign w_restart    = start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERROR));
   assign w_capture_hi = w_accept & ((r_state == LEN_HI) | (r_state == DATA_HI));
   assign w_pair       = {w_hi_byte, bus.rx_data};
   assign w_words_inc  = r_words + 16'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] w_csum;
`endif

   byte_pair_assembler u_bpa (
      .clk        (clk),
      .rst        (rst),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .clear      (w_restart),
      .accept     (w_accept),
      .csum       (w_csum),
`endif
      .capture_hi (w_capture_hi),
      .data       (bus.rx_data),
      .hi_byte    (w_hi_byte)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rx_ready  <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= BASE_ADDR;
         r_next_addr <= BASE_ADDR;
         r_wdata     <= '0;
         r_cpu_run   <= 1'b0;
         r_busy      <= 1'b0;
         r_error     <= 1'b0;
         r_words     <= 16'd0;
         r_len       <= 16'd0;
      end else begin
         r_we <= 1'b0;
         if (w_restart) begin
            r_state     <= LEN_HI;
            r_rx_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
            r_cpu_run   <= 1'b0;
            r_words     <= 16'd0;
            r_next_addr <= BASE_ADDR;
         end else begin
            case (r_state)
               LEN_HI: begin
                  if (w_accept) r_state <= LEN_LO;
               end
               LEN_LO: begin
                  if (w_accept) begin
                     r_len <= w_pair;
                     if ((w_pair == 16'd0) || (w_pair > c_max_words)) begin
                        r_state    <= ERROR;
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                     end else begin
                        r_state <= DATA_HI;
                     end
                  end
               end
               DATA_HI: begin
                  if (w_accept) r_state <= DATA_LO;
               end
               DATA_LO: begin
                  // Word is presented on the bus for the whole WRITE cycle
                  if (w_accept) begin
                     r_state    <= WRITE;
                     r_rx_ready <= 1'b0;
                     r_we       <= 1'b1;
                     r_addr     <= r_next_addr;
                     r_wdata    <= w_pair;
                  end
               end
               WRITE: begin
                  r_words     <= w_words_inc;
                  r_next_addr <= r_next_addr + c_pc_step;
                  if (w_words_inc < r_len) begin
                     r_state    <= DATA_HI;
                     r_rx_ready <= 1'b1;
                  end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     r_state    <= CSUM;
                     r_rx_ready <= 1'b1;
`else
                     r_state    <= DONE;
                     r_busy     <= 1'b0;
`endif
                  end
               end
`ifdef IMEM_LOADER_CHECKSUM_EN
               CSUM: begin
                  if (w_accept) begin
                     r_rx_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     if (bus.rx_data == w_csum) begin
                        r_state <= DONE;
                     end else begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                     end
                  end
               end
`endif
               DONE: begin
                  r_cpu_run <= 1'b1;
               end
               IDLE, ERROR: begin
                  r_rx_ready <= 1'b0;
               end
               default: begin
                  r_state    <= IDLE;
                  r_rx_ready <= 1'b0;
                  r_busy     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.rx_ready   = r_rx_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign cpu_run        = r_cpu_run;
   assign busy           = r_busy;
   assign error          = r_error;
   assign words_loaded   = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_prog_loader                                                      |
// | Directed, table-driven bench for imem_prog_loader.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_imem_prog_loader;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      int               nbytes;
      logic [0:11][7:0] bytes;
      bit               toggle;
      bit               exp_ok;
      int               exp_n;
      logic [0:2][15:0] exp_addr;
      logic [0:2][15:0] exp_data;
   } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic        cpu_run;
   logic        busy;
   logic        error;
   logic [15:0] words_loaded;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  run_xor;
   logic [15:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   vec_t        vecs[6];

   imem_prog_loader_if #(.ADDR_W(16)) bus ();

   imem_prog_loader #(
      .ADDR_W    (16),
      .MAX_WORDS (256),
      .BASE_ADDR (16'h0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus),
      .cpu_run      (cpu_run),
      .busy         (busy),
      .error        (error),
      .words_loaded (words_loaded)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_addr_q.push_back(bus.imem_addr);
         wr_data_q.push_back(bus.imem_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", what, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic do_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_xor = 8'h00;
      check({tag, "_start_busy"},    busy,          1);
      check({tag, "_start_cpu_run"}, cpu_run,       0);
      check({tag, "_start_error"},   error,         0);
      check({tag, "_start_words"},   words_loaded,  0);
      check({tag, "_start_rx_ready"}, bus.rx_ready, 1);
   endtask

   // Presents each byte until rx_ready is seen; the byte transfers on the following edge
   task automatic send_bytes(input bq_t b, input bit toggle, input bit add_csum);
      int waited;
      bq_t q;
      q = b;
      foreach (q[i]) run_xor = run_xor ^ q[i];
      if (add_csum && CSUM_EN) q.push_back(run_xor);
      foreach (q[i]) begin
         if (toggle) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
         end
         waited = 0;
         do begin
            @(negedge clk);
            bus.rx_data  = q[i];
            bus.rx_valid = 1'b1;
            waited++;
         end while (!bus.rx_ready && waited < 50);
         if (!bus.rx_ready) begin
            check("rx_ready_timeout", bus.rx_ready, 1);
            break;
         end
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("busy_timeout", busy, 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      bq_t q;
      string tag;
      tag = $sformatf("v%0d", idx);
      q = {};
      for (int k = 0; k < v.nbytes; k++) q.push_back(v.bytes[k]);
      clear_log();
      do_start(tag);
      send_bytes(q, v.toggle, v.exp_ok);
      wait_done();
      check({tag, "_nwrites"}, wr_addr_q.size(), v.exp_n);
      for (int k = 0; k < v.exp_n; k++) begin
         if (k < wr_addr_q.size()) begin
            check($sformatf("%s_addr%0d", tag, k), wr_addr_q[k], v.exp_addr[k]);
            check($sformatf("%s_data%0d", tag, k), wr_data_q[k], v.exp_data[k]);
         end
      end
      check({tag, "_error"},   error,        !v.exp_ok);
      check({tag, "_cpu_run"}, cpu_run,      v.exp_ok);
      check({tag, "_words"},   words_loaded, v.exp_n);
      check({tag, "_busy"},    busy,         0);
   endtask

   initial begin
      bq_t q;

      vecs[0] = '{8, {8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 32'h0}, 1'b0, 1'b1, 3,
                  {16'h0000, 16'h0002, 16'h0004}, {16'h1234, 16'h5678, 16'h9ABC}};
      vecs[1] = '{8, {8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 32'h0}, 1'b1, 1'b1, 3,
                  {16'h0000, 16'h0002, 16'h0004}, {16'h1234, 16'h5678, 16'h9ABC}};
      vecs[2] = '{2, {8'h00, 8'h00, 80'h0}, 1'b0, 1'b0, 0, 48'h0, 48'h0};
      vecs[3] = '{4, {8'h00, 8'h01, 8'hAB, 8'hCD, 64'h0}, 1'b0, 1'b1, 1,
                  {16'h0000, 32'h0}, {16'hABCD, 32'h0}};
      vecs[4] = '{2, {8'h01, 8'h01, 80'h0}, 1'b0, 1'b0, 0, 48'h0, 48'h0};
      vecs[5] = '{6, {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 48'h0}, 1'b1, 1'b1, 2,
                  {16'h0000, 16'h0002, 16'h0000}, {16'h1122, 16'h3344, 16'h0000}};

      rst          = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      run_xor      = 8'h00;
      @(negedge clk);
      @(negedge clk);
      check("rst_cpu_run",  cpu_run,        0);
      check("rst_busy",     busy,           0);
      check("rst_error",    error,          0);
      check("rst_words",    words_loaded,   0);
      check("rst_we",       bus.imem_we,    0);
      check("rst_addr",     bus.imem_addr,  16'h0000);
      check("rst_wdata",    bus.imem_wdata, 0);
      check("rst_rx_ready", bus.rx_ready,   0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

      // Asynchronous reset out of DONE: outputs clear before the next clock edge
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_cpu_run", cpu_run,       0);
      check("arst_words",   words_loaded,  0);
      check("arst_addr",    bus.imem_addr, 16'h0000);
      check("arst_wdata",   bus.imem_wdata, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of an image
      clear_log();
      do_start("mid");
      q = {8'h00, 8'h03, 8'h12, 8'h34, 8'h56};
      send_bytes(q, 1'b0, 1'b0);
      check("mid_pre_words", words_loaded, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy",     busy,         0);
      check("mid_rst_words",    words_loaded, 0);
      check("mid_rst_rx_ready", bus.rx_ready, 0);
      check("mid_rst_cpu_run",  cpu_run,      0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_post_cpu_run", cpu_run, 0);
      check("mid_post_busy",    busy,    0);

      // start and a valid byte in the same IDLE cycle: the byte must be ignored
      clear_log();
      @(negedge clk);
      start        = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h00;
      @(negedge clk);
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      run_xor      = 8'h00;
      q = {8'h00, 8'h01, 8'hAB, 8'hCD};
      send_bytes(q, 1'b0, 1'b1);
      wait_done();
      check("sv_nwrites", wr_addr_q.size(), 1);
      if (wr_data_q.size() > 0) check("sv_data0", wr_data_q[0], 16'hABCD);
      check("sv_error",   error,   0);
      check("sv_cpu_run", cpu_run, 1);

      // start while busy after the first word is ignored
      clear_log();
      do_start("sb");
      q = {8'h00, 8'h02, 8'h11, 8'h22};
      send_bytes(q, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("sb_busy_held", busy, 1);
      q = {8'h33, 8'h44};
      send_bytes(q, 1'b0, 1'b1);
      wait_done();
      check("sb_nwrites", wr_addr_q.size(), 2);
      if (wr_addr_q.size() == 2) begin
         check("sb_addr1", wr_addr_q[1], 16'h0002);
         check("sb_data1", wr_data_q[1], 16'h3344);
      end
      check("sb_error",   error,        0);
      check("sb_cpu_run", cpu_run,      1);
      check("sb_words",   words_loaded, 2);

      // Largest image: 256 words, last write at byte address 0x01FE
      clear_log();
      do_start("max");
      q = {8'h01, 8'h00};
      for (int i = 0; i < 256; i++) begin
         q.push_back(8'(i) ^ 8'h5A);
         q.push_back(8'(i));
      end
      send_bytes(q, 1'b0, 1'b1);
      wait_done();
      check("max_nwrites", wr_addr_q.size(), 256);
      if (wr_addr_q.size() == 256) begin
         check("max_addr0",   wr_addr_q[0],   16'h0000);
         check("max_data0",   wr_data_q[0],   16'h5A00);
         check("max_addr255", wr_addr_q[255], 16'h01FE);
         check("max_data255", wr_data_q[255], 16'hA5FF);
      end
      check("max_words",   words_loaded, 16'h0100);
      check("max_error",   error,        0);
      check("max_cpu_run", cpu_run,      1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      clear_log();
      do_start("cs_ok");
      q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
      send_bytes(q, 1'b0, 1'b0);
      wait_done();
      check("cs_ok_nwrites", wr_addr_q.size(), 1);
      check("cs_ok_error",   error,   0);
      check("cs_ok_cpu_run", cpu_run, 1);

      clear_log();
      do_start("cs_bad");
      q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h28};
      send_bytes(q, 1'b0, 1'b0);
      wait_done();
      check("cs_bad_nwrites", wr_addr_q.size(), 1);
      check("cs_bad_error",   error,   1);
      check("cs_bad_cpu_run", cpu_run, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
